// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU trace recorder.
// Optional build macro: TRACE_PC_FILTER_EN (see cpu_trace_recorder).
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } state_e;

    localparam int unsigned TRACE_XLEN = 32;
    localparam int unsigned TRACE_ILEN = 32;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_ILEN-1:0] instr;
    } trace_entry_t;

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int unsigned w
    );
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/cpu_trace_recorder_ring.sv
// Circular trace buffer with overwrite/drop policy and a drop counter.
// Output is first-word fall-through from the read pointer.
module trace_ring_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 64,
    parameter int unsigned WRAP  = 1,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] dropped_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             wr_en;
    logic             ovr;
    logic             do_pop;
    logic             empty;
    logic             full;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop = pop_i && !empty;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        wr_en  = 1'b0;
        ovr    = 1'b0;
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (push_i) begin
            if (!full || do_pop) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + PW'(1);
            end else if (WRAP != 0) begin
                // Full: the oldest slot is reused and the reader skips it.
                wr_en  = 1'b1;
                ovr    = 1'b1;
                wptr_d = wptr_q + PW'(1);
                rptr_d = rptr_q + PW'(1);
                drop_d = CNT_W'(sat_inc(64'(drop_q), CNT_W));
            end else begin
                drop_d = CNT_W'(sat_inc(64'(drop_q), CNT_W));
            end
        end
        if (wr_en && !do_pop && !ovr) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (!wr_en && do_pop) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && wr_en) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o    = empty ? '0 : mem_q[rptr_q];
    assign empty_o   = empty;
    assign full_o    = full;
    assign dropped_o = drop_q;

endmodule

// File: rtl/cpu_trace_recorder.sv
// Run control, cycle/retire counters and halt/timeout detection for ID-stage trace.
// Define TRACE_PC_FILTER_EN to add pc_lo_i/pc_hi_i push filtering.
module cpu_trace_recorder
    import cpu_trace_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ILEN       = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned HALT_ZEROS = 1,
    parameter int unsigned MAX_CYCLES = 4096,
    parameter int unsigned WRAP       = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [ILEN-1:0]  instr_i,
`ifdef TRACE_PC_FILTER_EN
    input  logic [XLEN-1:0]  pc_lo_i,
    input  logic [XLEN-1:0]  pc_hi_i,
`endif
    input  logic             pop_i,
    output logic [XLEN-1:0]  pop_pc_o,
    output logic [ILEN-1:0]  pop_instr_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] dropped_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic             halt_o,
    output logic             timeout_o
);

    localparam int unsigned EW = XLEN + ILEN;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [3:0]       zr_q, zr_d;
    logic [3:0]       zr_inc;
    logic             halt_hit;
    logic             budget_hit;
    logic             rec;
    logic             in_range;
    logic             push;
    logic [EW-1:0]    pop_data;

`ifdef TRACE_PC_FILTER_EN
    assign in_range = (pc_i >= pc_lo_i) && (pc_i <= pc_hi_i);
`else
    assign in_range = 1'b1;
`endif

    assign zr_inc     = 4'(sat_inc(64'(zr_q), 4));
    assign halt_hit   = valid_i && (instr_i == '0)
                        && (zr_inc >= 4'(HALT_ZEROS));
    assign budget_hit = (MAX_CYCLES != 0)
                        && (cyc_q == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        zr_d    = zr_q;
        rec     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (budget_hit && !halt_hit) begin
                    // Budget spent: this cycle does no work.
                    state_d = ST_TIMEOUT;
                end else begin
                    cyc_d = CNT_W'(sat_inc(64'(cyc_q), CNT_W));
                    if (valid_i && (instr_i != '0)) begin
                        rec   = 1'b1;
                        ret_d = CNT_W'(sat_inc(64'(ret_q), CNT_W));
                        zr_d  = '0;
                    end else if (valid_i) begin
                        zr_d = zr_inc;
                    end
                    if (halt_hit) state_d = ST_HALTED;
                end
            end
            ST_HALTED, ST_TIMEOUT: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            ret_q   <= '0;
            zr_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            zr_q    <= zr_d;
        end
    end

    assign push = rec && in_range;

    trace_ring_buffer #(
        .DEPTH (DEPTH),
        .W     (EW),
        .WRAP  (WRAP),
        .CNT_W (CNT_W)
    ) u_ring (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .data_i    ({pc_i, instr_i}),
        .pop_i     (pop_i),
        .data_o    (pop_data),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .dropped_o (dropped_o)
    );

    assign pop_pc_o      = pop_data[EW-1:ILEN];
    assign pop_instr_o   = pop_data[ILEN-1:0];
    assign cycle_cnt_o   = cyc_q;
    assign retired_cnt_o = ret_q;
    assign halt_o        = (state_q == ST_HALTED);
    assign timeout_o     = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_cpu_trace_recorder.sv
// Bench for cpu_trace_recorder: two instances (wrap/no-wrap) against a queue model.
// Builds with or without TRACE_PC_FILTER_EN (filter left wide open).
module tb_cpu_trace_recorder;

    logic        clk = 1'b0;
    logic        rst_i, start_i, valid_i, pop_i;
    logic [31:0] pc_i, instr_i;

    logic [31:0] pc_o [2];
    logic [31:0] in_o [2];
    logic [31:0] drop_o [2];
    logic [31:0] cyc_o [2];
    logic [31:0] ret_o [2];
    logic        emp_o [2];
    logic        full_o [2];
    logic        halt_o [2];
    logic        to_o [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cpu_trace_recorder #(
        .DEPTH(4), .HALT_ZEROS(1), .MAX_CYCLES(10), .WRAP(1)
    ) u0 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
`ifdef TRACE_PC_FILTER_EN
        .pc_lo_i(32'h0), .pc_hi_i(32'hffff_ffff),
`endif
        .pop_i(pop_i), .pop_pc_o(pc_o[0]), .pop_instr_o(in_o[0]),
        .empty_o(emp_o[0]), .full_o(full_o[0]),
        .dropped_o(drop_o[0]), .cycle_cnt_o(cyc_o[0]),
        .retired_cnt_o(ret_o[0]), .halt_o(halt_o[0]),
        .timeout_o(to_o[0])
    );

    cpu_trace_recorder #(
        .DEPTH(4), .HALT_ZEROS(2), .MAX_CYCLES(0), .WRAP(0)
    ) u1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .valid_i(valid_i), .pc_i(pc_i), .instr_i(instr_i),
`ifdef TRACE_PC_FILTER_EN
        .pc_lo_i(32'h0), .pc_hi_i(32'hffff_ffff),
`endif
        .pop_i(pop_i), .pop_pc_o(pc_o[1]), .pop_instr_o(in_o[1]),
        .empty_o(emp_o[1]), .full_o(full_o[1]),
        .dropped_o(drop_o[1]), .cycle_cnt_o(cyc_o[1]),
        .retired_cnt_o(ret_o[1]), .halt_o(halt_o[1]),
        .timeout_o(to_o[1])
    );

    // ---- model: 0 idle, 1 run, 2 halted, 3 timeout ----
    int          m_st [2];
    int          m_cyc [2];
    int          m_ret [2];
    int          m_zr [2];
    int          m_drop [2];
    int          m_n [2];
    logic [63:0] m_buf [2][4];

    task automatic m_shift(input int k);
        for (int j = 0; j < 3; j++) m_buf[k][j] = m_buf[k][j+1];
        m_n[k] = m_n[k] - 1;
    endtask

    task automatic model_step(input int k);
        int  hz, mx;
        bit  wrap, push, do_pop, hh;
        hz   = (k == 0) ? 1 : 2;
        mx   = (k == 0) ? 10 : 0;
        wrap = (k == 0);
        push = 1'b0;
        if (!rst_i) begin
            m_st[k] = 0; m_cyc[k] = 0; m_ret[k] = 0;
            m_zr[k] = 0; m_drop[k] = 0; m_n[k] = 0;
        end else begin
            do_pop = pop_i && (m_n[k] > 0);
            if (m_st[k] == 0) begin
                if (start_i) m_st[k] = 1;
            end else if (m_st[k] == 1) begin
                hh = valid_i && (instr_i == 0) && (m_zr[k] + 1 >= hz);
                if (!start_i) m_st[k] = 0;
                else if (mx != 0 && m_cyc[k] == mx - 1 && !hh)
                    m_st[k] = 3;
                else begin
                    m_cyc[k]++;
                    if (valid_i && instr_i != 0) begin
                        push = 1'b1; m_ret[k]++; m_zr[k] = 0;
                    end else if (valid_i && m_zr[k] < 15) begin
                        m_zr[k]++;
                    end
                    if (hh) m_st[k] = 2;
                end
            end
            if (do_pop) m_shift(k);
            if (push) begin
                if (m_n[k] == 4) begin
                    m_drop[k]++;
                    if (wrap) m_shift(k);
                end
                if (m_n[k] < 4) begin
                    m_buf[k][m_n[k]] = {pc_i, instr_i};
                    m_n[k]++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d: got %h want %h t=%0t",
                     nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [63:0] hd;
                hd = (m_n[k] > 0) ? m_buf[k][0] : 64'h0;
                chk("pop_pc", k, pc_o[k], hd[63:32]);
                chk("pop_instr", k, in_o[k], hd[31:0]);
                chk("empty", k, 32'(emp_o[k]), 32'(m_n[k] == 0));
                chk("full", k, 32'(full_o[k]), 32'(m_n[k] == 4));
                chk("dropped", k, drop_o[k], 32'(m_drop[k]));
                chk("cycle_cnt", k, cyc_o[k], 32'(m_cyc[k]));
                chk("retired", k, ret_o[k], 32'(m_ret[k]));
                chk("halt", k, 32'(halt_o[k]), 32'(m_st[k] == 2));
                chk("timeout", k, 32'(to_o[k]), 32'(m_st[k] == 3));
            end
        end
    end

    // ---- driver ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [31:0] pc, input logic [31:0] in);
        valid_i = 1'b1; pc_i = pc; instr_i = in;
        step();
        valid_i = 1'b0; pc_i = 32'h0; instr_i = 32'h0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0;
        step();
        rst_i = 1'b1;
    endtask

    task automatic pop_chk(input logic [31:0] e0, input logic [31:0] e1);
        chk("lit_pop_pc", 0, pc_o[0], e0);
        chk("lit_pop_pc", 1, pc_o[1], e1);
        pop_i = 1'b1;
        step();
        pop_i = 1'b0;
    endtask

    function automatic logic [31:0] epc(input int i);
        return 32'h100 + 32'(4 * i);
    endfunction

    function automatic logic [31:0] ein(input int i);
        return 32'h13 | (32'(i) << 20);
    endfunction

    initial begin
        rst_i = 1'b0; start_i = 1'b0; valid_i = 1'b0;
        pop_i = 1'b0; pc_i = 32'h0; instr_i = 32'h0;
        step();
        chk_en = 1'b1;
        step();
        rst_i = 1'b1;
        repeat (5) step();
        chk("lit_idle_cyc", 0, cyc_o[0], 32'd0);
        chk("lit_idle_empty", 0, 32'(emp_o[0]), 32'd1);

        // basic trace, halt on first zero for u0
        start_i = 1'b1;
        step();
        ins(32'h0, 32'h0050_0093);
        ins(32'h4, 32'h0060_0113);
        ins(32'h8, 32'h0020_81b3);
        ins(32'hc, 32'h0);
        chk("lit_halt", 0, 32'(halt_o[0]), 32'd1);
        chk("lit_halt", 1, 32'(halt_o[1]), 32'd0);
        chk("lit_retired", 0, ret_o[0], 32'd3);
        start_i = 1'b0;
        step();
        chk("lit_cyc_held", 1, cyc_o[1], 32'd4);
        pop_chk(32'h0, 32'h0);
        pop_chk(32'h4, 32'h4);
        pop_chk(32'h8, 32'h8);
        chk("lit_empty", 0, 32'(emp_o[0]), 32'd1);

        // overflow: wrap vs drop, then push+pop at full
        do_reset();
        start_i = 1'b1;
        step();
        for (int i = 1; i <= 6; i++) ins(epc(i), ein(i));
        chk("lit_full", 0, 32'(full_o[0]), 32'd1);
        chk("lit_drop", 0, drop_o[0], 32'd2);
        chk("lit_drop", 1, drop_o[1], 32'd2);
        pop_i = 1'b1;
        ins(epc(7), ein(7));
        pop_i = 1'b0;
        chk("lit_drop_pp", 1, drop_o[1], 32'd2);
        chk("lit_full_pp", 1, 32'(full_o[1]), 32'd1);
        start_i = 1'b0;
        step();
        pop_chk(epc(4), epc(2));
        pop_chk(epc(5), epc(3));
        pop_chk(epc(6), epc(4));
        chk("lit_pop_instr", 0, in_o[0], ein(7));
        pop_chk(epc(7), epc(7));
        // push+pop while empty
        start_i = 1'b1;
        step();
        pop_i = 1'b1;
        ins(epc(8), ein(8));
        pop_i = 1'b0;
        chk("lit_empty_pp", 0, 32'(emp_o[0]), 32'd0);
        start_i = 1'b0;
        pop_chk(epc(8), epc(8));

        // timeout after 10 RUN cycles on u0
        do_reset();
        start_i = 1'b1;
        step();
        for (int i = 0; i <= 8; i++) ins(epc(i), ein(i + 1));
        chk("lit_to_pre", 0, 32'(to_o[0]), 32'd0);
        ins(epc(9), ein(10));
        chk("lit_timeout", 0, 32'(to_o[0]), 32'd1);
        chk("lit_to_cyc", 0, cyc_o[0], 32'd9);
        ins(epc(10), ein(11));
        ins(epc(11), ein(12));
        chk("lit_to_ret", 0, ret_o[0], 32'd9);
        chk("lit_to_drop", 0, drop_o[0], 32'd5);
        chk("lit_nw_drop", 1, drop_o[1], 32'd8);
        start_i = 1'b0;
        pop_chk(epc(5), epc(0));

        // zero-run broken by bubbles and by a real instruction
        do_reset();
        start_i = 1'b1;
        step();
        ins(32'h200, 32'h0050_0093);
        ins(32'h204, 32'h0);
        step();
        ins(32'h208, 32'h0060_0113);
        ins(32'h20c, 32'h0);
        step();
        step();
        chk("lit_hz2_pre", 1, 32'(halt_o[1]), 32'd0);
        ins(32'h210, 32'h0);
        chk("lit_hz2", 1, 32'(halt_o[1]), 32'd1);
        chk("lit_hz2_ret", 1, ret_o[1], 32'd2);

        // halt beats timeout in the same cycle
        do_reset();
        start_i = 1'b1;
        step();
        for (int i = 0; i <= 8; i++) ins(epc(i), ein(i + 1));
        ins(epc(9), 32'h0);
        chk("lit_hvt_halt", 0, 32'(halt_o[0]), 32'd1);
        chk("lit_hvt_to", 0, 32'(to_o[0]), 32'd0);
        chk("lit_hvt_cyc", 0, cyc_o[0], 32'd10);

        // reset in the middle of RUN
        do_reset();
        start_i = 1'b1;
        step();
        ins(epc(1), ein(1));
        ins(epc(2), ein(2));
        rst_i = 1'b0;
        ins(epc(3), ein(3));
        rst_i = 1'b1;
        chk("lit_mrst_empty", 0, 32'(emp_o[0]), 32'd1);
        chk("lit_mrst_ret", 0, ret_o[0], 32'd0);
        step();
        chk("lit_mrst_idle", 0, cyc_o[0], 32'd0);
        step();
        chk("lit_mrst_run", 0, cyc_o[0], 32'd1);
        start_i = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_trace_recorder.md
Name: cpu_trace_recorder

Overview:
- Synthesizable run-control and trace block that attaches to the pipelined RISC-V CPU's ID-stage signals: PC and ID-stage instruction.
- Counts cycles and retired instructions, and stores (PC, instruction) pairs in a circular buffer.
- Detects halt as N consecutive all-zero instructions, and enforces a cycle-budget timeout.
- Replaces the per-cycle dump-and-stop-on-zero behaviour that the simulation bench implements today; the bench and later FPGA debug logic read the buffer through a pop port.

Parameters:
- XLEN, 32, width of PC and stored PC field
- ILEN, 32, instruction width
- DEPTH, 16, trace buffer entries; power of two, minimum 2
- HALT_ZEROS, 1, consecutive zero instructions that declare halt (1..15)
- MAX_CYCLES, 4096, cycle budget before timeout; 0 disables timeout
- WRAP, 1, 1 = overwrite oldest entry when full; 0 = drop new entries when full
- CNT_W, 32, width of the cycle and retire counters

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-low reset
- start_i  in  1  level; run permitted while high
- valid_i  in  1  ID-stage instruction valid (not a bubble/stall)
- pc_i  in  XLEN  PC of the ID-stage instruction
- instr_i  in  ILEN  ID-stage instruction
- pop_i  in  1  read request for the oldest entry
- pop_pc_o  out  XLEN  PC of the oldest entry
- pop_instr_o  out  ILEN  instruction of the oldest entry
- empty_o  out  1  buffer empty
- full_o  out  1  buffer full
- dropped_o  out  CNT_W  entries overwritten (WRAP=1) or rejected (WRAP=0); saturating
- cycle_cnt_o  out  CNT_W  cycles spent in RUN
- retired_cnt_o  out  CNT_W  valid non-zero instructions recorded
- halt_o  out  1  HALTED state
- timeout_o  out  1  TIMEOUT state

Behaviour:
- Reset, sampled on clk_i while rst_i=0: every output is 0 except empty_o=1; pointers, counters and zero-run counter are cleared; state goes to IDLE. Reset asserted mid-RUN aborts immediately, with no partial effects that cycle.
- State machine, one transition per clock:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0; counters are held, not cleared.
  - RUN -> HALTED when the zero-run counter reaches HALT_ZEROS.
  - RUN -> TIMEOUT when cycle_cnt reaches MAX_CYCLES-1 and MAX_CYCLES != 0.
  - HALTED and TIMEOUT are sticky until reset.
  - If halt and timeout trigger in the same cycle, halt wins.
- In RUN, each cycle:
  - cycle_cnt increments.
  - If valid_i=1 and instr_i != 0: push (pc_i, instr_i), increment retired_cnt, clear the zero-run counter.
  - If valid_i=1 and instr_i == 0: increment the zero-run counter; the entry is not stored.
  - If valid_i=0: the zero-run counter is held.
- Push/pop:
  - Buffer is DEPTH entries with read/write pointers plus a count, log2(DEPTH)+1 bits.
  - Pop output is combinational from the read pointer (first-word fall-through). pop_i while empty is ignored.
  - Full with WRAP=1: the new entry overwrites the oldest, the read pointer advances, dropped_o increments.
  - Full with WRAP=0: the new entry is discarded, dropped_o increments.
  - Simultaneous push and pop while full: the pop is honoured, the push is stored, dropped is unchanged.
  - Simultaneous push and pop while empty: the push is stored and the pop is ignored.
- Pops are permitted in every state; pushes occur only in RUN.
- All counters saturate at all-ones and never wrap.
- Latency: a pushed entry is visible on pop_*_o and reflected in empty_o in the cycle after the push edge.

Optional Feature:
- TRACE_PC_FILTER_EN defined: adds inputs pc_lo_i and pc_hi_i (XLEN each). Only instructions with pc_lo_i <= pc_i <= pc_hi_i (unsigned comparison) are pushed. Retire counting and halt detection are unaffected by the filter.
- Undefined: the ports are absent and every qualifying instruction is pushed.

Decomposition:
- Package cpu_trace_pkg holds:
  - the state enum (IDLE, RUN, HALTED, TIMEOUT);
  - the trace entry struct {pc, instr};
  - the saturating-increment function.
- One sub-module, trace_ring_buffer: parametrised DEPTH/entry-width circular buffer implementing the WRAP policy and the drop counter. The FSM and counters stay in the top.

Test Plan:
- Reset and idle: hold rst_i=0 for 2 cycles, then start_i=0 for 5 cycles -> every output 0, empty_o=1, cycle_cnt_o=0.
- Basic trace: start; 3 valid instructions at PC 0,4,8 (0x00500093...), then 1 zero instruction with HALT_ZEROS=1 -> halt_o=1 on the following cycle; retired_cnt_o=3; pops return PCs 0,4,8 in order, then empty_o=1.
- Wrap overflow: DEPTH=4, WRAP=1, push 6 entries -> full_o=1, dropped_o=2, pops return entries 3..6.
- No-wrap drop: DEPTH=4, WRAP=0, push 6 entries -> dropped_o=2, pops return entries 1..4.
- Timeout and halt timing:
  - MAX_CYCLES=10, non-zero instructions throughout -> timeout_o=1 after exactly 10 RUN cycles, cycle_cnt_o=9; further valid_i is ignored.
  - HALTED: zero-run broken by valid_i=0 bubbles with HALT_ZEROS=2 -> HALTED only after the second valid zero.
- Mid-run reset and simultaneous push/pop: push/pop in the same cycle at full and at empty -> counts as specified; rst_i=0 during RUN -> state IDLE and buffer empty next cycle.
